// File: rtl/dram_tx_responder.sv
// Target side of the TX_ENQ/TX_COMP DRAM handshake: in-order request queue,
// one request in service at a time with fixed read/write latency.
module dram_tx_responder #(
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 8,
  parameter int WR_LAT = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_tx_enq,
  input  logic                     io_is_wr,
  input  logic [ADDR_W-1:0]        io_addr,
  output logic                     io_enq_rdy,
  output logic                     io_tx_comp,
  output logic                     io_comp_is_wr,
  output logic [ADDR_W-1:0]        io_comp_addr,
  output logic [$clog2(DEPTH):0]   io_pending,
  output logic                     io_busy,
  output logic                     io_overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] RD_L  = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] WR_L  = CNT_W'(WR_LAT);
  localparam logic [CNT_W-1:0] CNT_1 = CNT_W'(1);
  localparam logic [PTR_W:0]   FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE   = (PTR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_COMP
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nx;

  logic                r_q_wr   [DEPTH];
  logic [ADDR_W-1:0]   r_q_addr [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [PTR_W-1:0]    w_rptr_nxt;
  logic [PTR_W:0]      r_pending;
  logic                r_overflow;

  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic                w_pop;

  function automatic logic [CNT_W-1:0] lat_of(input logic wr);
    return wr ? WR_L : RD_L;
  endfunction

  assign w_full     = (r_pending == FULL);
  assign w_empty    = (r_pending == '0);
  assign w_accept   = io_tx_enq & ~w_full;
  assign w_pop      = (r_state == S_COMP);
  assign w_rptr_nxt = r_rptr + PTR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_q_wr[i]   <= 1'b0;
        r_q_addr[i] <= '0;
      end
    end else if (w_accept) begin
      r_q_wr[r_wptr]   <= io_is_wr;
      r_q_addr[r_wptr] <= io_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)    r_rptr <= w_rptr_nxt;
      if (io_tx_enq && w_full) r_overflow <= 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_pending <= r_pending + ONE;
        2'b01:   r_pending <= r_pending - ONE;
        default: r_pending <= r_pending;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Service starts in the accept cycle itself (LAT-1 loaded from the incoming
  // request), or the cycle after a COMP (full LAT loaded during COMP), which
  // places every completion at max(accept, prev_comp+1) + LAT.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_cnt_nx   = lat_of(r_q_wr[r_rptr]) - CNT_1;
          w_state_nx = S_WAIT;
        end else if (w_accept) begin
          w_cnt_nx   = lat_of(io_is_wr) - CNT_1;
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_nx = r_cnt - CNT_1;
        if (r_cnt == CNT_1) w_state_nx = S_COMP;
      end
      S_COMP: begin
        if (r_pending > ONE) begin
          w_cnt_nx   = lat_of(r_q_wr[w_rptr_nxt]);
          w_state_nx = S_WAIT;
        end else if (w_accept) begin
          w_cnt_nx   = lat_of(io_is_wr);
          w_state_nx = S_WAIT;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign io_enq_rdy    = ~w_full;
  assign io_tx_comp    = w_pop;
  assign io_comp_is_wr = w_pop & r_q_wr[r_rptr];
  assign io_comp_addr  = w_pop ? r_q_addr[r_rptr] : '0;
  assign io_pending    = r_pending;
  assign io_busy       = (r_state != S_IDLE);
  assign io_overflow   = r_overflow;

endmodule

// File: tb/tb_dram_tx_responder.sv
// Bench for dram_tx_responder: timestamp scoreboard, directed vector table and
// hand-written sequences for reset, overflow and back-to-back corners.
module tb_dram_tx_responder;

  localparam int ADDR_W = 64;
  localparam int DEPTH  = 4;
  localparam int RD_LAT = 8;
  localparam int WR_LAT = 5;

  logic              clk;
  logic              reset;
  logic              io_tx_enq;
  logic              io_is_wr;
  logic [ADDR_W-1:0] io_addr;
  logic              io_enq_rdy;
  logic              io_tx_comp;
  logic              io_comp_is_wr;
  logic [ADDR_W-1:0] io_comp_addr;
  logic [$clog2(DEPTH):0] io_pending;
  logic              io_busy;
  logic              io_overflow;

  dram_tx_responder #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .RD_LAT(RD_LAT),
    .WR_LAT(WR_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io_tx_enq    (io_tx_enq),
    .io_is_wr     (io_is_wr),
    .io_addr      (io_addr),
    .io_enq_rdy   (io_enq_rdy),
    .io_tx_comp   (io_tx_comp),
    .io_comp_is_wr(io_comp_is_wr),
    .io_comp_addr (io_comp_addr),
    .io_pending   (io_pending),
    .io_busy      (io_busy),
    .io_overflow  (io_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: each accepted request gets its completion cycle stamped at accept time.
  typedef struct {
    logic        wr;
    logic [63:0] addr;
    int          due;
  } ent_t;

  ent_t mq[$];
  logic m_ovf = 1'b0;
  int   last_due = -1000;
  int   n0;
  logic ecomp;
  ent_t ne;

  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      m_ovf    = 1'b0;
      last_due = -1000;
    end else begin
      n0 = mq.size();
      chk("pending",  io_pending,  n0);
      chk("enq_rdy",  io_enq_rdy,  n0 < DEPTH);
      chk("busy",     io_busy,     n0 != 0);
      chk("overflow", io_overflow, m_ovf);
      ecomp = (n0 != 0) && (mq[0].due == cyc);
      chk("tx_comp", io_tx_comp, ecomp);
      if (ecomp) begin
        chk("comp_addr",  io_comp_addr,  mq[0].addr);
        chk("comp_is_wr", io_comp_is_wr, mq[0].wr);
        void'(mq.pop_front());
      end
      if (io_tx_enq) begin
        if (n0 >= DEPTH) begin
          m_ovf = 1'b1;
        end else begin
          ne.wr   = io_is_wr;
          ne.addr = io_addr;
          ne.due  = ((cyc > last_due + 1) ? cyc : last_due + 1) + (io_is_wr ? WR_LAT : RD_LAT);
          last_due = ne.due;
          mq.push_back(ne);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic wr, input logic [63:0] a);
    io_tx_enq = 1'b1;
    io_is_wr  = wr;
    io_addr   = a;
    cycle();
    io_tx_enq = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_comp"}, io_tx_comp,    0);
    chk({tag, "_is_wr"},   io_comp_is_wr, 0);
    chk({tag, "_addr"},    io_comp_addr,  0);
    chk({tag, "_pending"}, io_pending,    0);
    chk({tag, "_busy"},    io_busy,       0);
    chk({tag, "_ovf"},     io_overflow,   0);
    chk({tag, "_rdy"},     io_enq_rdy,    1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check_reset_outputs("rst");
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic wait_comp(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (io_tx_comp) begin
        at = cyc;
        break;
      end
    end
  endtask

  typedef struct {
    logic        enq;
    logic [63:0] addr;
    int          reps;
    logic        rdy;
    int          pend;
    logic        ovf;
    logic        comp;
    logic [63:0] caddr;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input logic enq, input logic [63:0] addr, input int reps,
                              input logic rdy, input int pend, input logic ovf,
                              input logic comp, input logic [63:0] caddr);
    vec_t v;
    v.enq = enq; v.addr = addr; v.reps = reps; v.rdy = rdy;
    v.pend = pend; v.ovf = ovf; v.comp = comp; v.caddr = caddr;
    return v;
  endfunction

  int a0, a1, t0, t1, ncomp, w;

  initial begin
    reset     = 1'b1;
    io_tx_enq = 1'b0;
    io_is_wr  = 1'b0;
    io_addr   = '0;

    // Five back-to-back writes into a 4-deep queue; completions every WR_LAT+1.
    vt[0]  = mk(1, 64'hA0, 1, 1, 0, 0, 0, 0);
    vt[1]  = mk(1, 64'hA1, 1, 1, 1, 0, 0, 0);
    vt[2]  = mk(1, 64'hA2, 1, 1, 2, 0, 0, 0);
    vt[3]  = mk(1, 64'hA3, 1, 1, 3, 0, 0, 0);
    vt[4]  = mk(1, 64'hA4, 1, 0, 4, 0, 0, 0);
    vt[5]  = mk(0, 64'h0,  1, 0, 4, 1, 1, 64'hA0);
    vt[6]  = mk(0, 64'h0,  5, 1, 3, 1, 0, 0);
    vt[7]  = mk(0, 64'h0,  1, 1, 3, 1, 1, 64'hA1);
    vt[8]  = mk(0, 64'h0,  5, 1, 2, 1, 0, 0);
    vt[9]  = mk(0, 64'h0,  1, 1, 2, 1, 1, 64'hA2);
    vt[10] = mk(0, 64'h0,  5, 1, 1, 1, 0, 0);
    vt[11] = mk(0, 64'h0,  1, 1, 1, 1, 1, 64'hA3);
    vt[12] = mk(0, 64'h0,  3, 1, 0, 1, 0, 0);

    repeat (3) cycle();
    do_reset();

    // Single read from idle
    repeat (10) cycle();
    a0 = cyc;
    enq(1'b0, 64'h1000);
    wait_comp(30, t0);
    chk("t1_comp_cycle", t0, a0 + RD_LAT);
    chk("t1_comp_addr",  io_comp_addr,  64'h1000);
    chk("t1_comp_is_wr", io_comp_is_wr, 0);
    cycle();

    // Read then write on consecutive cycles
    do_reset();
    repeat (10) cycle();
    a0 = cyc;
    enq(1'b0, 64'h1000);
    a1 = cyc;
    enq(1'b1, 64'h2000);
    wait_comp(30, t0);
    chk("t2_first_cycle", t0, a0 + RD_LAT);
    chk("t2_first_addr",  io_comp_addr, 64'h1000);
    wait_comp(30, t1);
    chk("t2_second_cycle", t1, a0 + RD_LAT + 1 + WR_LAT);
    chk("t2_second_addr",  io_comp_addr,  64'h2000);
    chk("t2_second_is_wr", io_comp_is_wr, 1);
    cycle();

    // Vector table: fill, overflow, drain
    do_reset();
    foreach (vt[k]) begin
      for (int r = 0; r < vt[k].reps; r++) begin
        io_tx_enq = vt[k].enq;
        io_is_wr  = 1'b1;
        io_addr   = vt[k].addr;
        @(negedge clk);
        chk($sformatf("vec%0d_rdy", k),     io_enq_rdy,  vt[k].rdy);
        chk($sformatf("vec%0d_pending", k), io_pending,  vt[k].pend);
        chk($sformatf("vec%0d_ovf", k),     io_overflow, vt[k].ovf);
        chk($sformatf("vec%0d_comp", k),    io_tx_comp,  vt[k].comp);
        if (vt[k].comp) chk($sformatf("vec%0d_caddr", k), io_comp_addr, vt[k].caddr);
        cycle();
      end
    end
    io_tx_enq = 1'b0;

    // Enqueue during a COMP while full: dropped, pop does not make room
    do_reset();
    for (int i = 0; i < DEPTH; i++) enq(1'b1, 64'hB0 + 64'(i));
    cycle();
    io_tx_enq = 1'b1;
    io_is_wr  = 1'b0;
    io_addr   = 64'hBEEF;
    @(negedge clk);
    chk("t4_comp_now", io_tx_comp, 1);
    chk("t4_rdy_now",  io_enq_rdy, 0);
    cycle();
    io_tx_enq = 1'b0;
    @(negedge clk);
    chk("t4_pending_after", io_pending,  DEPTH - 1);
    chk("t4_ovf_after",     io_overflow, 1);
    for (int i = 0; i < 40 && mq.size() != 0; i++) cycle();
    cycle();

    // Reset in the middle of WAIT with three pending
    do_reset();
    for (int i = 0; i < 3; i++) enq(1'b0, 64'hC0 + 64'(i));
    cycle();
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_outputs("t5_midreset");
    cycle();
    cycle();
    reset = 1'b0;
    ncomp = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (io_tx_comp) ncomp++;
    end
    chk("t5_comps_after_reset", ncomp, 0);
    cycle();
    a0 = cyc;
    enq(1'b0, 64'hD00);
    wait_comp(30, t0);
    chk("t5_full_latency", t0, a0 + RD_LAT);
    chk("t5_addr",         io_comp_addr, 64'hD00);
    cycle();

    // Randomised alternating reads/writes against the scoreboard
    do_reset();
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 5)) cycle();
      w = 0;
      while (!io_enq_rdy && w < 50) begin
        cycle();
        w++;
      end
      chk("t6_rdy_wait", io_enq_rdy, 1);
      enq(i[0], {$urandom, $urandom});
    end
    for (int i = 0; i < 400 && mq.size() != 0; i++) cycle();
    chk("t6_drained", mq.size(), 0);
    cycle();
    chk("t6_pending_zero", io_pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
